regdst_arbiter: RTL
===================

# regdst_arbiter

Parametrised, registered successor to the register-destination selector. It arbitrates among `NUM_CH` producer channels, each carrying a `WIDTH`-bit register index, and holds the winner in a one-entry output register with a valid/ready handshake. It sits between the control unit's destination sources and the register-file write port of the multicycle datapath. It supports direct-select mode and round-robin mode, and constant channels that always offer a fixed value.

## Interface
Parameters:
- `WIDTH`, 5: data width (register index).
- `NUM_CH`, 4: channel count, ≥2.
- `SEL_W`, `$clog2(NUM_CH)`: select/channel-id width.
- `CONST_MASK`, `4'b0010`: bit i set means channel i is a constant channel.
- `CONST_VAL`, 0: value offered by every constant channel.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high.
- `mode`  in  1  0 = direct select, 1 = round-robin.
- `sel`  in  `SEL_W`  channel requested in direct mode.
- `in_valid`  in  `NUM_CH`  per-channel valid; ignored for constant channels.
- `in_data`  in  `NUM_CH*WIDTH`  channel i at bits `[i*WIDTH +: WIDTH]`; ignored for constant channels.
- `in_ready`  out  `NUM_CH`  one-hot grant/accept, combinational.
- `out_valid`  out  1  output register holds a value.
- `out_data`  out  `WIDTH`  registered selected value.
- `out_ch`  out  `SEL_W`  channel id of `out_data`.
- `out_ready`  in  1  consumer accepts this cycle.

## Operation
- State is `EMPTY` or `FULL`. This state is identical to `out_valid`.
- `load = !out_valid || out_ready`. A grant may occur only when `load` is 1.
- Direct mode:
  - The candidate is `sel`. If `sel >= NUM_CH`, the candidate is channel 0.
  - A constant candidate is always eligible. It loads `CONST_VAL`.
  - A non-constant candidate is eligible only when its `in_valid` is 1.
- Round-robin mode:
  - Constant channels are never eligible.
  - The search starts at `(ptr+1) mod NUM_CH` and wraps. The first channel with `in_valid=1` wins.
- On a grant:
  - `in_ready[g]=1`, all other bits 0.
  - Register `out_data`/`out_ch` and set `out_valid=1`.
  - In round-robin mode only, `ptr <= g`.
- No eligible channel while `load=1`:
  - If `out_ready=1`, clear `out_valid`.
  - If `out_valid` was already 0, it stays 0.
  - `out_data` and `out_ch` hold their previous values.
- FULL and `out_ready=0`: all `in_ready=0`; outputs hold.
- Simultaneous drain and refill (FULL, `out_ready=1`, eligible channel present): the new value replaces the old one in the same edge. `out_valid` stays 1. There is no bubble.
- A change of `mode` or `sel` while FULL affects only the next grant. `ptr` is kept across mode changes.
- Reset values:
  - `out_valid=0`, `out_data=0`, `out_ch=0`.
  - `ptr=NUM_CH-1`, so the first round-robin search starts at channel 0.
  - `in_ready=0` while `reset` is asserted.
- Reset mid-transfer discards the held value immediately (asynchronous). No grant is issued during reset.

## Timing
- Latency: the grant cycle (`in_ready[g]=1`) is followed by `out_valid=1` with the data in the next cycle. Latency is 1.
- Throughput: one transfer per cycle while `out_ready=1`.
- `in_ready` depends combinationally on `in_valid`, `sel`, `mode`, `out_valid` and `out_ready`. It has no combinational path from `in_data`.
- `out_valid`, `out_data` and `out_ch` are register outputs only.
- Producers must hold `in_valid`/`in_data` until they see `in_ready`. The block never drops a granted value.

## Structure
- Shared package:
  - mode encoding constants `MODE_DIRECT=1'b0`, `MODE_RR=1'b1`.
  - the `EMPTY`/`FULL` state type.
- One sub-module, `rr_pick`: a combinational round-robin first-one finder.
  - Inputs: request vector, `ptr`.
  - Outputs: one-hot grant and encoded index.
  - Parametrised by `NUM_CH`.
- The top level holds the direct-select path, the output register and `ptr`.

## Test plan
- Reset: assert `reset` mid-cycle with the block FULL → `out_valid=0`, `out_data=0`, `out_ch=0` immediately. After release, the first round-robin grant goes to channel 0.
- Direct mode, `sel=1`, `in_valid=0` → `in_ready=4'b0010`. The next cycle shows `out_data=0`, `out_ch=1`.
- Direct mode, `sel=2`, `in_data[2]=5'd17`:
  - With `in_valid[2]=0` → no grant.
  - Raise `in_valid[2]` → `out_data=17` one cycle later.
- Round-robin with `in_valid=4'b1101` and constant `out_ready=1` → grants in order ch0, ch2, ch3, ch0. Channel 1 is never granted.
- Backpressure: FULL with `out_ready=0` for 3 cycles → `in_ready=0` and outputs stable. On `out_ready=1` with ch3 valid → refill in the same edge, `out_valid` stays 1.
- Direct mode, `sel=3'd7` (NUM_CH=4, SEL_W=3 build) → channel 0 is selected.

Source files
------------

// File: rtl/regdst_arbiter_pkg.sv
// Shared definitions for the register-destination arbiter: mode encodings
// and the output-register occupancy state.
package regdst_arbiter_pkg;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_RR     = 1'b1;

  // The output register is either empty or holds one value; this state is
  // exported directly as out_valid.
  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } arb_state_t;

endpackage

// File: rtl/regdst_arbiter_rr_pick.sv
// Combinational round-robin first-one finder. The search begins at the
// channel just above ptr and wraps, so the channel at ptr has lowest priority.
module rr_pick #(
  parameter int NUM_CH = 4,
  parameter int SEL_W  = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] i_req,
  input  logic [SEL_W-1:0]  i_ptr,
  output logic [NUM_CH-1:0] o_gnt,
  output logic [SEL_W-1:0]  o_idx
);

  logic w_found;

  // Two ascending passes (above ptr, then at/below ptr) keep every index
  // constant after unrolling while giving the wrapped search order.
  always_comb begin
    o_gnt   = '0;
    o_idx   = '0;
    w_found = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (!w_found && i_req[i] && (i > int'(i_ptr))) begin
        o_gnt[i] = 1'b1;
        o_idx    = SEL_W'(i);
        w_found  = 1'b1;
      end
    end
    for (int i = 0; i < NUM_CH; i++) begin
      if (!w_found && i_req[i] && (i <= int'(i_ptr))) begin
        o_gnt[i] = 1'b1;
        o_idx    = SEL_W'(i);
        w_found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regdst_arbiter.sv
// Registered register-destination arbiter. Picks one of NUM_CH producer
// channels (direct select or round-robin) and holds the winner in a one-entry
// output register with a valid/ready handshake toward the register file.
module regdst_arbiter
  import regdst_arbiter_pkg::*;
#(
  parameter int                WIDTH      = 5,
  parameter int                NUM_CH     = 4,
  parameter int                SEL_W      = $clog2(NUM_CH),
  parameter logic [NUM_CH-1:0] CONST_MASK = 4'b0010,
  parameter logic [WIDTH-1:0]  CONST_VAL  = '0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    mode,
  input  logic [SEL_W-1:0]        sel,
  input  logic [NUM_CH-1:0]       in_valid,
  input  logic [NUM_CH*WIDTH-1:0] in_data,
  output logic [NUM_CH-1:0]       in_ready,
  output logic                    out_valid,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_ch,
  input  logic                    out_ready
);

  arb_state_t        r_state;
  logic [WIDTH-1:0]  r_out_data;
  logic [SEL_W-1:0]  r_out_ch;
  logic [SEL_W-1:0]  r_ptr;

  logic              w_load;
  logic [NUM_CH-1:0] w_dir_oh;
  logic [SEL_W-1:0]  w_dir_idx;
  logic              w_dir_elig;
  logic [WIDTH-1:0]  w_dir_data;

  logic [NUM_CH-1:0] w_rr_req;
  logic [NUM_CH-1:0] w_rr_oh;
  logic [SEL_W-1:0]  w_rr_idx;
  logic              w_rr_elig;
  logic [WIDTH-1:0]  w_rr_data;

  logic [NUM_CH-1:0] w_gnt_oh;
  logic [SEL_W-1:0]  w_gnt_idx;
  logic [WIDTH-1:0]  w_gnt_data;
  logic              w_elig;
  logic              w_grant;

  // Decode sel into a one-hot candidate; out-of-range selects fall back to ch0.
  always_comb begin
    w_dir_oh  = '0;
    w_dir_idx = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (int'(sel) == i) begin
        w_dir_oh[i] = 1'b1;
        w_dir_idx   = SEL_W'(i);
      end
    end
    if (w_dir_oh == '0) begin
      w_dir_oh[0] = 1'b1;
    end
  end

  // Direct candidate eligibility and data; constant channels always offer.
  always_comb begin
    w_dir_elig = |(w_dir_oh & (in_valid | CONST_MASK));
    w_dir_data = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (w_dir_oh[i]) begin
        w_dir_data = CONST_MASK[i] ? CONST_VAL : in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // Constant channels never take part in round-robin.
  assign w_rr_req = in_valid & ~CONST_MASK;

  rr_pick #(
    .NUM_CH (NUM_CH),
    .SEL_W  (SEL_W)
  ) u_rr_pick (
    .i_req (w_rr_req),
    .i_ptr (r_ptr),
    .o_gnt (w_rr_oh),
    .o_idx (w_rr_idx)
  );

  // Round-robin winner data mux.
  always_comb begin
    w_rr_elig = |w_rr_oh;
    w_rr_data = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (w_rr_oh[i]) begin
        w_rr_data = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // Mode select and grant qualification; in_data only feeds the data path.
  always_comb begin
    w_load = (r_state == ST_EMPTY) || out_ready;
    if (mode == MODE_RR) begin
      w_gnt_oh   = w_rr_oh;
      w_gnt_idx  = w_rr_idx;
      w_gnt_data = w_rr_data;
      w_elig     = w_rr_elig;
    end else begin
      w_gnt_oh   = w_dir_oh;
      w_gnt_idx  = w_dir_idx;
      w_gnt_data = w_dir_data;
      w_elig     = w_dir_elig;
    end
    w_grant  = w_load && !reset && w_elig;
    in_ready = w_grant ? w_gnt_oh : '0;
  end

  // Output register, occupancy state and round-robin pointer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_EMPTY;
      r_out_data <= '0;
      r_out_ch   <= '0;
      r_ptr      <= SEL_W'(NUM_CH - 1);
    end else if (w_load) begin
      if (w_grant) begin
        r_state    <= ST_FULL;
        r_out_data <= w_gnt_data;
        r_out_ch   <= w_gnt_idx;
        if (mode == MODE_RR) begin
          r_ptr <= w_gnt_idx;
        end
      end else if (out_ready) begin
        r_state <= ST_EMPTY;
      end
    end
  end

  assign out_valid = (r_state == ST_FULL);
  assign out_data  = r_out_data;
  assign out_ch    = r_out_ch;

endmodule
